// File: rtl/data_bus_ctrl.sv
// data_bus_ctrl: load/store bus controller for the multi-cycle RV32I core.
// Takes one load/store request at a time from the control FSM, issues a
// single valid/ready bus transaction with byte enables and a word-aligned
// address, bounds memory wait states with a timeout, and returns extended
// load data together with a one-cycle done (and err) pulse.
//
// Bus handshake: bus_valid is high for every cycle the controller sits in
// ACCESS; bus_we/bus_addr/bus_be/bus_wdata are constant for that whole
// window. A transfer completes on the first rising edge where bus_valid
// and bus_ready are both high; bus_valid then drops the following cycle.
// If bus_ready never arrives within TIMEOUT valid cycles the request is
// withdrawn (bus_valid drops) and the access reports err.
module data_bus_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic        busy,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  // Last wait-counter value before an access without ready is abandoned.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  // Width codes as delivered on funct3.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // FSM state is kept as a named register so checkers can bind to it.
  state_t state;
  state_t state_next;

  // Request context captured in IDLE.
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  offset_q;
  logic        err_q;

  // Wait-state counter for the current ACCESS.
  logic [7:0]  wait_cnt;

  // Request decode (only meaningful while IDLE samples req).
  logic        illegal;
  logic        misaligned;
  logic        reject;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;

  // Load path.
  logic [31:0] rdata_shifted;
  logic [31:0] load_ext;

  // Timeout and completion qualifiers in ACCESS.
  logic        timeout_hit;
  logic        load_done;

  // Classify the incoming request: unknown width codes and unsigned stores are illegal.
  always_comb begin
    illegal = 1'b0;
    case (funct3)
      F3_B, F3_H, F3_W: illegal = 1'b0;
      F3_BU, F3_HU:     illegal = we;
      default:          illegal = 1'b1;
    endcase
  end

  // Halfwords need an even address, words need a 4-byte aligned address.
  always_comb begin
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = (addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  assign reject = illegal | misaligned;

  // Byte enables follow the access width and the low address bits.
  always_comb begin
    be_calc = 4'b0000;
    case (funct3[1:0])
      2'b00:   be_calc = 4'b0001 << addr[1:0];
      2'b01:   be_calc = 4'b0011 << addr[1:0];
      2'b10:   be_calc = 4'b1111;
      default: be_calc = 4'b0000;
    endcase
  end

  // Store data is replicated across all lanes so memory can pick by byte enable.
  always_comb begin
    wdata_calc = wdata;
    case (funct3[1:0])
      2'b00:   wdata_calc = {4{wdata[7:0]}};
      2'b01:   wdata_calc = {2{wdata[15:0]}};
      default: wdata_calc = wdata;
    endcase
  end

  // Align the addressed lane down to bit 0, then sign- or zero-extend.
  always_comb begin
    rdata_shifted = bus_rdata >> {offset_q, 3'b000};
    load_ext      = rdata_shifted;
    case (funct3_q)
      F3_B:    load_ext = {{24{rdata_shifted[7]}},  rdata_shifted[7:0]};
      F3_H:    load_ext = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      F3_BU:   load_ext = {24'h000000, rdata_shifted[7:0]};
      F3_HU:   load_ext = {16'h0000,   rdata_shifted[15:0]};
      default: load_ext = rdata_shifted;
    endcase
  end

  // Ready on the final allowed cycle wins over the timeout.
  assign timeout_hit = (state == ACCESS) && !bus_ready && (wait_cnt == LAST_WAIT);
  assign load_done   = (state == ACCESS) && bus_ready && !we_q;

  // Next-state decode for the IDLE -> ACCESS -> RESP -> IDLE sequence.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req) begin
          state_next = reject ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (bus_ready || timeout_hit) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture the request and its bus image in IDLE; flag errors on reject or timeout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q      <= 1'b0;
      funct3_q  <= 3'b000;
      offset_q  <= 2'b00;
      err_q     <= 1'b0;
      bus_addr  <= 32'h0000_0000;
      bus_be    <= 4'b0000;
      bus_wdata <= 32'h0000_0000;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            we_q      <= we;
            funct3_q  <= funct3;
            offset_q  <= addr[1:0];
            err_q     <= reject;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= be_calc;
            bus_wdata <= wdata_calc;
          end
        end
        ACCESS: begin
          if (timeout_hit) begin
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Count ACCESS cycles without ready; cleared while IDLE so each access starts at 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= 8'd0;
    end else if (state == ACCESS) begin
      if (!bus_ready) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end else begin
      wait_cnt <= 8'd0;
    end
  end

  // Load result register: only a successful load updates it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata <= 32'h0000_0000;
    end else if (load_done) begin
      rdata <= load_ext;
    end
  end

  // Status and bus qualifiers decode straight from state, so reset drops them at once.
  assign busy      = (state != IDLE);
  assign bus_valid = (state == ACCESS);
  assign bus_we    = (state == ACCESS) && we_q;
  assign done      = (state == RESP);
  assign err       = (state == RESP) && err_q;

endmodule

// File: tb/tb_data_bus_ctrl.sv
// tb_data_bus_ctrl: directed bench for data_bus_ctrl with a scoreboard.
// Drivers push expected bus images and responses; independent monitors
// compare them against what the DUT presents.
module tb_data_bus_ctrl;

  localparam int TIMEOUT = 16;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [7:0]  cycles;
  } bus_exp_t;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
    logic [31:0] issue;
    logic [31:0] lat;
  } resp_exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic        busy;
  logic        bus_valid;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata;

  bus_exp_t  bus_q[$];
  resp_exp_t resp_q[$];

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int wait_cfg = 0;
  int wait_left = 0;
  int vcount = 0;
  logic abort_mode = 1'b0;

  data_bus_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .we        (we),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .done      (done),
    .err       (err),
    .busy      (busy),
    .bus_valid (bus_valid),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_ready (bus_ready),
    .bus_rdata (bus_rdata)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Memory model: holds ready low for wait_cfg valid cycles, then raises it.
  always @(negedge clk) begin
    if (bus_valid) begin
      if (wait_left == 0) bus_ready = 1'b1;
      else begin
        bus_ready = 1'b0;
        wait_left--;
      end
    end else begin
      bus_ready = 1'b0;
      wait_left = wait_cfg;
    end
  end

  // Bus monitor: every valid cycle must show the expected, stable bus image.
  always @(negedge clk) begin
    if (abort_mode) begin
      vcount = 0;
    end else if (bus_valid) begin
      if (bus_q.size() == 0) begin
        check("bus_unexpected_valid", {63'd0, bus_valid}, 64'd0);
      end else begin
        check("bus_addr", {32'd0, bus_addr}, {32'd0, bus_q[0].addr});
        check("bus_we_be_wdata", {27'd0, bus_we, bus_be, bus_wdata},
              {27'd0, bus_q[0].we, bus_q[0].be, bus_q[0].wdata});
        vcount++;
      end
    end else if (vcount > 0) begin
      check("bus_valid_cycles", 64'(vcount), {56'd0, bus_q[0].cycles});
      void'(bus_q.pop_front());
      vcount = 0;
    end
  end

  // Response monitor: each done pulse is matched to the oldest expected response.
  always @(negedge clk) begin
    resp_exp_t e;
    if (done) begin
      if (resp_q.size() == 0) begin
        check("unexpected_done", {63'd0, done}, 64'd0);
      end else begin
        e = resp_q.pop_front();
        check("resp_err", {63'd0, err}, {63'd0, e.err});
        check("resp_rdata", {32'd0, rdata}, {32'd0, e.rdata});
        check("resp_latency", 64'(cyc - int'(e.issue) + 1), {32'd0, e.lat});
      end
    end
  end

  // Issue one access, scramble inputs while it runs, and wait (bounded) for done.
  task automatic run_vec(input logic v_we, input logic [2:0] v_f3, input logic [31:0] v_addr,
                         input logic [31:0] v_wdata, input logic [31:0] v_brdata, input int v_wait,
                         input logic [31:0] e_baddr, input logic [3:0] e_be, input logic [31:0] e_bwdata,
                         input int e_cycles, input logic e_err, input logic [31:0] e_rdata, input int e_lat);
    bit got;
    @(posedge clk); #1;
    we = v_we; funct3 = v_f3; addr = v_addr; wdata = v_wdata;
    bus_rdata = v_brdata; wait_cfg = v_wait; req = 1'b1;
    resp_q.push_back('{err: e_err, rdata: e_rdata, issue: 32'(cyc + 1), lat: 32'(e_lat)});
    if (e_cycles > 0)
      bus_q.push_back('{addr: e_baddr, we: v_we, be: e_be, wdata: e_bwdata, cycles: 8'(e_cycles)});
    @(posedge clk); #1;
    req = 1'b0; we = ~v_we; funct3 = 3'b111; addr = 32'hFFFF_FFFF; wdata = 32'h5A5A_5A5A;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    check("done_seen", {63'd0, got}, 64'd1);
  endtask

  initial begin
    reset_n = 1'b0; req = 1'b0; we = 1'b0; funct3 = 3'b000;
    addr = 32'd0; wdata = 32'd0; bus_rdata = 32'd0;
    #22;
    check("reset_rdata", {32'd0, rdata}, 64'd0);
    check("reset_flags", {59'd0, done, err, busy, bus_valid, bus_we}, 64'd0);
    check("reset_bus", {28'd0, bus_be, bus_addr}, 64'd0);
    check("reset_wdata", {32'd0, bus_wdata}, 64'd0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Loads with extension.
    run_vec(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 32'h100, 4'b1111, 32'h0, 1, 1'b0, 32'hDEADBEEF, 2);
    run_vec(1'b0, 3'b000, 32'h103, 32'h0, 32'h80123456, 0, 32'h100, 4'b1000, 32'h0, 1, 1'b0, 32'hFFFFFF80, 2);
    run_vec(1'b0, 3'b101, 32'h102, 32'h0, 32'h80123456, 0, 32'h100, 4'b1100, 32'h0, 1, 1'b0, 32'h00008012, 2);
    run_vec(1'b0, 3'b001, 32'h102, 32'h0, 32'h80123456, 0, 32'h100, 4'b1100, 32'h0, 1, 1'b0, 32'hFFFF8012, 2);
    run_vec(1'b0, 3'b100, 32'h101, 32'h0, 32'h80123456, 2, 32'h100, 4'b0010, 32'h0, 3, 1'b0, 32'h00000034, 4);
    // Stores leave rdata alone.
    run_vec(1'b1, 3'b000, 32'h201, 32'h000000AB, 32'hFFFFFFFF, 3, 32'h200, 4'b0010, 32'hABABABAB, 4, 1'b0, 32'h00000034, 5);
    run_vec(1'b1, 3'b001, 32'h202, 32'h1234CDEF, 32'hFFFFFFFF, 1, 32'h200, 4'b1100, 32'hCDEFCDEF, 2, 1'b0, 32'h00000034, 3);
    run_vec(1'b1, 3'b010, 32'h300, 32'h11223344, 32'hFFFFFFFF, 0, 32'h300, 4'b1111, 32'h11223344, 1, 1'b0, 32'h00000034, 2);
    // Rejected: no bus cycle, done/err one cycle after the request edge.
    run_vec(1'b0, 3'b010, 32'h102, 32'h0, 32'hFFFFFFFF, 0, 32'h0, 4'b0, 32'h0, 0, 1'b1, 32'h00000034, 1);
    run_vec(1'b1, 3'b001, 32'h101, 32'h0, 32'hFFFFFFFF, 0, 32'h0, 4'b0, 32'h0, 0, 1'b1, 32'h00000034, 1);
    run_vec(1'b1, 3'b100, 32'h200, 32'h0, 32'hFFFFFFFF, 0, 32'h0, 4'b0, 32'h0, 0, 1'b1, 32'h00000034, 1);
    run_vec(1'b0, 3'b011, 32'h100, 32'h0, 32'hFFFFFFFF, 0, 32'h0, 4'b0, 32'h0, 0, 1'b1, 32'h00000034, 1);
    // Timeout, then ready arriving on the last allowed cycle.
    run_vec(1'b0, 3'b010, 32'h400, 32'h0, 32'h55555555, 100, 32'h400, 4'b1111, 32'h0, 16, 1'b1, 32'h00000034, 17);
    run_vec(1'b0, 3'b010, 32'h404, 32'h0, 32'h0BADF00D, 15, 32'h404, 4'b1111, 32'h0, 16, 1'b0, 32'h0BADF00D, 17);

    // Reset in the middle of an access.
    @(posedge clk); #1;
    abort_mode = 1'b1;
    we = 1'b0; funct3 = 3'b010; addr = 32'h500; wdata = 32'h0; wait_cfg = 100; req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("rst_mid_flags", {59'd0, done, err, busy, bus_valid, bus_we}, 64'd0);
    check("rst_mid_rdata", {32'd0, rdata}, 64'd0);
    check("rst_mid_bus", {28'd0, bus_be, bus_addr}, 64'd0);
    check("rst_mid_wdata", {32'd0, bus_wdata}, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    abort_mode = 1'b0;
    run_vec(1'b0, 3'b010, 32'h100, 32'h0, 32'hCAFEF00D, 0, 32'h100, 4'b1111, 32'h0, 1, 1'b0, 32'hCAFEF00D, 2);

    repeat (4) @(posedge clk);
    check("resp_q_drained", 64'(resp_q.size()), 64'd0);
    check("bus_q_drained", 64'(bus_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Global bound on simulated time.
  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected bench end before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/data_bus_ctrl.md
# data_bus_ctrl

Load/store bus controller for the multi-cycle RV32I core. It sits between the datapath/control FSM and the data memory bus. It accepts one load or store request at a time, using the funct3 width code (`strb`) and the write strobe (`busWe`) produced by the control unit. It drives a valid/ready memory bus with byte enables and a word-aligned address, waits out memory wait states with a timeout, then returns sign- or zero-extended load data plus a one-cycle completion pulse that the control FSM uses to leave its memory state.

## Interface
Parameters:
- TIMEOUT, 16: maximum number of bus cycles in ACCESS without `bus_ready` before the access is aborted with an error. Legal range 2..255.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset_n  input  1  reset, asynchronous, active-low
- req  input  1  access request from the control FSM; sampled only in IDLE
- we  input  1  1 = store, 0 = load (driven from `busWe`)
- funct3  input  3  width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (driven from `strb`)
- addr  input  32  byte address (ALU result)
- wdata  input  32  store data (rs2)
- rdata  output  32  extended load result; holds until the next successful load
- done  output  1  one-cycle pulse when the access completes, successfully or not
- err  output  1  one-cycle pulse coincident with `done` on a misaligned, illegal or timed-out access
- busy  output  1  high whenever the FSM is not in IDLE
- bus_valid  output  1  bus request
- bus_we  output  1  bus write
- bus_addr  output  32  `{addr[31:2], 2'b00}`
- bus_be  output  4  byte enables
- bus_wdata  output  32  lane-replicated store data
- bus_ready  input  1  memory accepts the write, or read data is valid, this cycle
- bus_rdata  input  32  memory read word

## Operation
- **FSM states:** IDLE, ACCESS, RESP.
- **IDLE:**
  - On `req=1`, latch `we`, `funct3`, `addr[1:0]`, `bus_addr`, `bus_be` and `bus_wdata`.
  - If the access is legal and aligned, go to ACCESS. Otherwise go to RESP with the error flag set; no bus cycle is issued.
- **Legality:**
  - funct3 011, 110 and 111 are illegal.
  - 100 and 101 are illegal when `we=1`.
- **Alignment:**
  - H/HU require `addr[0]=0`.
  - W requires `addr[1:0]=00`.
- **Byte enables:**
  - B/BU: `4'b0001 << addr[1:0]`.
  - H/HU: `4'b0011 << addr[1:0]`.
  - W: `4'b1111`.
- **Store data:**
  - B: `{4{wdata[7:0]}}`.
  - H: `{2{wdata[15:0]}}`.
  - W: `wdata`.
- **ACCESS:**
  - `bus_valid=1`, `bus_we` = latched `we`.
  - Address, enables and data stay stable until `bus_ready`.
  - On `bus_ready=1`, go to RESP. For a load, also update `rdata` from `bus_rdata >> (8*addr[1:0])`, then sign-extend (B, H) or zero-extend (BU, HU) from bit 7 or bit 15; W is taken as-is.
  - A wait counter resets to 0 on ACCESS entry and increments each cycle without ready. If the counter equals TIMEOUT-1 and `bus_ready=0`, go to RESP with the error flag set, drop `bus_valid`, and leave `rdata` unchanged.
- **RESP:** `done=1`, `err` = error flag; return to IDLE next cycle.
- **Ignored inputs:** `req` is ignored outside IDLE. Input changes during ACCESS have no effect, because everything is latched.
- **Stores and errors** never modify `rdata`.

## Timing
- **Reset values:** state IDLE; `rdata`=0, `done`=0, `err`=0, `busy`=0, `bus_valid`=0, `bus_we`=0, `bus_addr`=0, `bus_be`=0, `bus_wdata`=0.
- **Reset mid-access:** asserting `reset_n` low drops `bus_valid` immediately, asynchronously; no completion pulse is produced.
- **Cycle numbering:** `req` is sampled at edge N.
  - `bus_valid` rises at N+1.
  - With `bus_ready` already high at N+1, RESP and `done` are at N+2. Minimum latency is 2 cycles.
  - Each wait state adds 1 cycle.
- **Rejected access:** `done`/`err` at N+1, and `bus_valid` never asserts.
- **Timeout:** `bus_valid` is high for exactly TIMEOUT cycles, and `done`/`err` follow at the next cycle.
- **Ready on the last timeout cycle:** ready wins, and the access completes successfully.
- **Loaded data:** `rdata` is registered and valid in the same cycle `done` is high.
- **Back-to-back accesses:** with `req` held high, a new access is accepted the cycle after RESP. Maximum throughput is one access per 3 cycles.
- **Outputs:** `busy`, `bus_*`, `done` and `err` are driven from registers or state decode only; there is no combinational path from `req` to the bus.

## Test plan
- **LW, zero wait:** `addr`=0x100, `bus_ready` tied high, `bus_rdata`=0xDEADBEEF -> `bus_addr`=0x100, `bus_be`=1111, `done` at N+2, `rdata`=0xDEADBEEF, `err`=0.
- **LB / LHU extension:** LB `addr`=0x103 with `bus_rdata`=0x80123456 -> `rdata`=0xFFFFFF80. LHU `addr`=0x102 with `bus_rdata`=0x80123456 -> `rdata`=0x00008012.
- **SB with wait states:** `addr`=0x201, `wdata`=0x000000AB, `bus_ready` low for 3 cycles -> `bus_be`=0010, `bus_wdata`=0xABABABAB stable for 4 `bus_valid` cycles, `done` 1 cycle after ready, `rdata` unchanged.
- **Misaligned or illegal:** LW `addr`=0x102, SH `addr`=0x101, and store with `funct3`=100 -> `bus_valid` never high, `done`=`err`=1 at N+1.
- **Timeout:** `bus_ready` held low with TIMEOUT=16 -> `bus_valid` high for exactly 16 cycles, then `done`=`err`=1. Repeat with ready arriving on cycle 16 -> success, `err`=0.
- **Reset mid-access:** assert `reset_n` low during ACCESS -> `bus_valid`=0 immediately, all outputs at reset values, no `done`. Next LW after release completes normally.
